vga_scanout: RTL and testbench

Scan-out engine for the VGA display path. It runs in the `clk_in` domain and advances one pixel per `pix_ce` strobe from the pixel-rate divider. It generates 640x480@60 raster timing (hsync, vsync, data-enable) and pulls RGB444 pixels from an upstream valid/ready stream. It detects stream underflow and frame misalignment, and realigns on the next start-of-frame word.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_raster_counter.sv | 56 +++++
 rtl/vga_scanout.sv | 118 +++++++++++
 tb/tb_vga_scanout.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA definitions.
//   VGA_* constants : 640x480@60 raster timing (pixels / lines)
//   state_t         : scan-out stream state {WAIT_SOF, RUN}
//   rgb444_t        : packed {r,g,b} pixel, 4 bits per channel
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
endpackage

// File: rtl/vga_raster_counter.sv
// vga_raster_counter: horizontal/vertical raster position with timing decode.
//   clk_in, reset  : clock, asynchronous active-high reset
//   pix_ce         : pixel strobe; counters advance only when high
//   h_cnt, v_cnt   : current raster position
//   active         : position lies inside the visible area
//   hs_act, vs_act : position lies inside the horizontal / vertical sync pulse
module vga_raster_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hs_act,
  output logic       vs_act
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  always_comb begin
    h_cnt_d = !pix_ce ? h_cnt_q : (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d = !(pix_ce && h_cnt_q == H_LAST) ? v_cnt_q :
              (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end
  assign h_cnt  = h_cnt_q;
  assign v_cnt  = v_cnt_q;
  assign active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hs_act = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
  assign vs_act = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster generator fed by an RGB444 valid/ready pixel stream.
//   clk_in, reset        : clock, asynchronous active-high reset
//   pix_ce               : pixel strobe; all raster state and outputs advance on it
//   enable               : allow streaming; low blanks video and drops sync with the stream
//   s_valid/s_ready      : stream handshake (s_ready combinational, never from s_data)
//   s_data, s_sof        : RGB444 pixel and first-pixel-of-frame marker
//   vga_r/g/b, hsync, vsync, de, x, y : registered video outputs for the last strobed position
//   frame_start          : one-clock pulse on the update that outputs (0,0)
//   underflow, sof_err   : sticky stream error flags
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] s_data,
  input  logic        s_sof,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        underflow,
  output logic        sof_err
);
  logic [9:0] h_cnt, v_cnt;
  logic       active, hs_act, vs_act;
  vga_raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .clk_in(clk_in), .reset(reset), .pix_ce(pix_ce),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .active(active), .hs_act(hs_act), .vs_act(vs_act)
  );
  state_t     state_q, state_d;
  rgb444_t    rgb_q, rgb_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       frame_start_q, frame_start_d, underflow_q, underflow_d, sof_err_q, sof_err_d;
  logic       run, at_origin, take_sof, uf_set, sof_set, shown;
  always_comb begin
    run       = state_q == RUN;
    at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    take_sof  = !run && pix_ce && enable && s_valid && s_sof && at_origin;
    uf_set    = run && pix_ce && enable && active && !s_valid;
    sof_set   = run && pix_ce && enable && active && s_valid && s_sof && !at_origin;
    // While waiting, non-SOF words drain every clock; the SOF word itself is
    // taken only on the (0,0) strobe. A disabled RUN consumes nothing.
    s_ready   = !reset && (run ? pix_ce && enable && active && s_valid && !(s_sof && !at_origin)
                               : (enable && s_valid && !s_sof) || take_sof);
    shown     = run ? s_ready : take_sof;
    state_d   = !pix_ce ? state_q :
                run ? ((!enable || uf_set || sof_set) ? WAIT_SOF : RUN) :
                (take_sof ? RUN : WAIT_SOF);
    rgb_d         = !pix_ce ? rgb_q : shown ? rgb444_t'(s_data) : rgb444_t'(12'd0);
    hsync_d       = !pix_ce ? hsync_q : hs_act ? SYNC_POL : !SYNC_POL;
    vsync_d       = !pix_ce ? vsync_q : vs_act ? SYNC_POL : !SYNC_POL;
    de_d          = pix_ce ? active : de_q;
    x_d           = pix_ce ? h_cnt : x_q;
    y_d           = pix_ce ? v_cnt : y_q;
    frame_start_d = pix_ce && at_origin;
    underflow_d   = underflow_q || uf_set;
    sof_err_d     = sof_err_q || sof_set;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_SOF;
      rgb_q         <= '0;
      hsync_q       <= !SYNC_POL;
      vsync_q       <= !SYNC_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      sof_err_q     <= sof_err_d;
    end
  end
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign sof_err     = sof_err_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks vga_scanout (reduced raster 8x4 in a 15x8 frame) against
// a position-based reference model every clock, plus hand-computed expectations.
module tb_vga_scanout;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int FA = HA * VA;

  logic        clk_in = 0, reset = 1, pix_ce = 0, enable = 0;
  logic        s_valid = 0, s_sof = 0;
  logic [11:0] s_data = 0;
  logic        s_ready, hsync, vsync, de, frame_start, underflow, sof_err;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [9:0]  x, y;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .clk_in(clk_in), .reset(reset), .pix_ce(pix_ce), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
    .de(de), .x(x), .y(y), .frame_start(frame_start),
    .underflow(underflow), .sof_err(sof_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // source stream: {sof, data}
  logic [12:0] q[$];
  bit          vld_en = 1;
  logic        acc = 0, ce_last = 0;

  // reference model: frame position and whether the stream is aligned to it
  int          m_pos = 0;
  bit          m_sync = 0, m_uf = 0, m_se = 0;
  logic [11:0] e_rgb = 0;
  logic        e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0;
  int          e_x = 0, e_y = 0;

  // measurements taken from checked outputs
  int          strobes, de_cnt, acc_cnt, period, de_last, acc_last, fs_seen;
  int          since_hs, line_len, hs_run, hs_len, hs_fall_x, vs_run, vs_len, vs_fall_y;
  logic [11:0] fs_rgb, px1;
  logic        hs_prev, vs_prev;

  int          ph, pv;
  bit          m_act, m_org, m_rdy, upd;
  logic [11:0] rgb;

  always @(negedge clk_in) begin
    rgb = {vga_r, vga_g, vga_b};
    upd = ce_last;
    if (reset) begin
      m_pos = 0; m_sync = 0; m_uf = 0; m_se = 0;
      e_rgb = 0; e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
      strobes = 0; de_cnt = 0; acc_cnt = 0; period = 0; de_last = 0; acc_last = 0; fs_seen = 0;
      since_hs = 0; line_len = 0; hs_run = 0; hs_len = 0; hs_fall_x = -1;
      vs_run = 0; vs_len = 0; vs_fall_y = -1; fs_rgb = 0; px1 = 0; hs_prev = 1; vs_prev = 1;
    end
    chk("rgb", rgb, e_rgb);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("de", de, e_de);
    chk("x", x, e_x);
    chk("y", y, e_y);
    chk("frame_start", frame_start, e_fs);
    chk("underflow", underflow, m_uf);
    chk("sof_err", sof_err, m_se);
    ph = m_pos % HT;
    pv = m_pos / HT;
    m_act = ph < HA && pv < VA;
    m_org = m_pos == 0;
    m_rdy = reset ? 1'b0 :
            !m_sync ? (enable && s_valid && (!s_sof || (pix_ce && m_org))) :
            (pix_ce && enable && m_act && s_valid && !(s_sof && !m_org));
    chk("s_ready", s_ready, m_rdy);
    acc = s_ready && s_valid;
    if (!reset && upd) begin
      strobes++;
      since_hs++;
      if (de) de_cnt++;
      if (frame_start) begin
        fs_seen++; fs_rgb = rgb; period = strobes; strobes = 0;
        de_last = de_cnt; de_cnt = 0; acc_last = acc_cnt; acc_cnt = 0;
      end
      if (x == 1 && y == 0) px1 = rgb;
      if (!hsync && hs_prev) begin hs_fall_x = x; line_len = since_hs; since_hs = 0; hs_run = 0; end
      if (!hsync) hs_run++;
      if (hsync && !hs_prev) hs_len = hs_run;
      if (!vsync && vs_prev) begin vs_fall_y = y; vs_run = 0; end
      if (!vsync) vs_run++;
      if (vsync && !vs_prev) vs_len = vs_run;
      hs_prev = hsync;
      vs_prev = vsync;
    end
    if (!reset) acc_cnt += int'(acc);
    e_fs = 0;
    if (!reset && pix_ce) begin
      if (!m_sync) begin
        if (enable && s_valid && s_sof && m_org) begin m_sync = 1; e_rgb = s_data; end
        else e_rgb = 0;
      end else if (!enable) begin m_sync = 0; e_rgb = 0; end
      else if (!m_act) e_rgb = 0;
      else if (!s_valid) begin m_uf = 1; m_sync = 0; e_rgb = 0; end
      else if (s_sof && !m_org) begin m_se = 1; m_sync = 0; e_rgb = 0; end
      else e_rgb = s_data;
      e_x = ph;
      e_y = pv;
      e_de = m_act;
      e_hs = !(ph >= HA + HFP && ph < HA + HFP + HS);
      e_vs = !(pv >= VA + VFP && pv < VA + VFP + VS);
      e_fs = m_org;
      m_pos = (m_pos + 1) % FT;
    end
    ce_last = reset ? 1'b0 : pix_ce;
  end

  task automatic step(input bit ce);
    @(posedge clk_in);
    #1;
    if (acc && q.size() > 0) void'(q.pop_front());
    pix_ce  = ce;
    s_valid = vld_en && q.size() > 0;
    {s_sof, s_data} = (q.size() > 0) ? q[0] : 13'd0;
  endtask

  task automatic advance(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic push_frame(input logic [11:0] base);
    q.push_back({1'b1, 12'hF00});
    for (int i = 1; i < FA; i++) q.push_back({1'b0, base + 12'(i)});
  endtask

  task automatic do_reset();
    reset = 1;
    q.delete();
    for (int i = 0; i < 8; i++) step(i % 4 == 0);
    #2;
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_xy", {x, y}, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_flags", {frame_start, underflow, sof_err}, 0);
    reset = 0;
  endtask

  int gp[7] = '{1, 3, 2, 5, 1, 4, 2};

  initial begin
    enable = 1;
    do_reset();
    // stream fidelity and full-frame timing
    push_frame(12'h000); push_frame(12'h000); push_frame(12'h000);
    advance(3 * FT, 1);
    chk("fid_frames", fs_seen, 3);
    chk("fid_pix00", fs_rgb, 12'hF00);
    chk("fid_pix10", px1, 12'h001);
    chk("fid_words_per_frame", acc_last, 32);
    chk("fid_de_per_frame", de_last, 32);
    chk("fid_frame_period", period, 120);
    chk("fid_hsync_start_x", hs_fall_x, 10);
    chk("fid_hsync_len", hs_len, 3);
    chk("fid_line_len", line_len, 15);
    chk("fid_vsync_line", vs_fall_y, 5);
    chk("fid_vsync_len", vs_len, 30);
    chk("fid_underflow", underflow, 0);
    // underflow at (3,2), then resync on next frame
    do_reset();
    q.push_back({1'b1, 12'hF00});
    for (int i = 1; i < 19; i++) q.push_back({1'b0, 12'(i)});
    advance(FT, 1);
    chk("uf_flag", underflow, 1);
    chk("uf_no_sof_err", sof_err, 0);
    push_frame(12'h100);
    advance(10, 1);
    chk("uf_resync_pix00", fs_rgb, 12'hF00);
    chk("uf_resync_pix10", px1, 12'h101);
    chk("uf_sticky", underflow, 1);
    // early SOF at (5,0)
    do_reset();
    push_frame(12'h000);
    for (int i = 1; i <= 5; i++) q.push_back({1'b0, 12'(i)});
    push_frame(12'h200);
    advance(130, 1);
    chk("se_flag", sof_err, 1);
    chk("se_no_underflow", underflow, 0);
    chk("se_sof_kept", q.size(), 32);
    advance(130, 1);
    chk("se_realign_pix00", fs_rgb, 12'hF00);
    chk("se_realign_pix10", px1, 12'h201);
    // junk words ahead of SOF are flushed between strobes
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back({1'b0, 12'hABC});
    push_frame(12'h300);
    for (int i = 0; i < 48; i++) step(i % 4 == 3);
    chk("junk_frames", fs_seen, 1);
    chk("junk_pix00", fs_rgb, 12'hF00);
    chk("junk_pix10", px1, 12'h301);
    chk("junk_queue", q.size(), 24);
    // irregular strobes with enable dropped mid-line
    do_reset();
    push_frame(12'h400); push_frame(12'h500);
    for (int i = 0; i < 200; i++) begin
      if (i == 20) enable = 0;
      if (i == 23) enable = 1;
      advance(1, gp[i % 7]);
    end
    chk("gap_underflow", underflow, 0);
    chk("gap_sof_err", sof_err, 0);
    chk("gap_pix00", fs_rgb, 12'hF00);
    chk("gap_pix10", px1, 12'h501);
    // asynchronous reset mid-line
    advance(7, 1);
    #2;
    reset = 1;
    #1;
    chk("arst_xy", {x, y}, 0);
    chk("arst_de", de, 0);
    chk("arst_sync", {hsync, vsync}, 2'b11);
    chk("arst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("arst_s_ready", s_ready, 0);
    step(1'b0);
    step(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
